prio_encode_arb: RTL and testbench

//  Parametrised, registered successor of the 8-to-3 priority encoder. Latches

---
 rtl/prio_encode_arb.sv | 116 +++++++++++
 tb/tb_prio_encode_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prio_encode_arb.sv
// prio_encode_arb
//   Registered priority encoder / arbiter. Incoming request bits are latched
//   into a sticky pending vector; the highest (or lowest, LSB_FIRST=1) pending
//   index is offered over a valid/ready handshake and cleared on acceptance.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | nothing offered, out_valid=0, out_idx=0
//   OFFER | out_idx is offered, held stable until accepted or cleared
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   ena         accept new requests and make new offers
//   req         request bits, each 1 sets its pending bit
//   clr_all     clear the whole pending vector and drop any offer
//   out_valid   an index is offered
//   out_ready   consumer accepts when out_valid & out_ready
//   out_idx     offered index, 0 when out_valid=0
//   pending     registered pending vector
//   any_pending OR of the pending vector
module prio_encode_arb #(
    parameter int WIDTH     = 8,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] req,
    input  logic             clr_all,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] pending,
    output logic             any_pending
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] pending_q, pending_n;
    logic [WIDTH-1:0] acc_mask, req_gated;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             acc;

    // Scan order decides priority: the last set bit visited wins.
    function automatic logic [IDX_W-1:0] sel(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (v[i]) r = IDX_W'(i);
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign acc       = (state_q == OFFER) & out_ready;
    assign acc_mask  = acc ? ({{(WIDTH-1){1'b0}}, 1'b1} << idx_q) : '0;
    // AND-gating keeps an unknown req out of the pending vector while ena=0.
    assign req_gated = req & {WIDTH{ena}};

    always_comb begin
        // Served bit is cleared before new requests are OR-ed in, so a
        // same-cycle request on the accepted bit re-arms it.
        pending_n = clr_all ? '0 : ((pending_q & ~acc_mask) | req_gated);
        state_n   = state_q;
        idx_n     = idx_q;
        case (state_q)
            IDLE: begin
                if (ena && (|pending_n) && !clr_all) begin
                    state_n = OFFER;
                    idx_n   = sel(pending_n);
                end
            end
            OFFER: begin
                if (clr_all) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (acc) begin
                    if (ena && (|pending_n)) begin
                        idx_n = sel(pending_n);
                    end else begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_n;
            pending_q <= pending_n;
            idx_q     <= idx_n;
        end
    end

    assign out_valid   = (state_q == OFFER);
    assign out_idx     = idx_q;
    assign pending     = pending_q;
    assign any_pending = |pending_q;

endmodule

// File: tb/tb_prio_encode_arb.sv
module tb_prio_encode_arb;

    logic       clk;
    logic       rst;
    logic       ena, clr_all, out_ready;
    logic [7:0] req;
    logic       out_valid, any_pending;
    logic [2:0] out_idx;
    logic [7:0] pending;

    logic       u1_ena, u1_clr, u1_rdy, u1_valid, u1_any;
    logic [7:0] u1_req, u1_pending;
    logic [2:0] u1_idx;

    logic        u2_ena, u2_clr, u2_rdy, u2_valid, u2_any;
    logic [31:0] u2_req, u2_pending;
    logic [4:0]  u2_idx;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_pend;
    logic       m_valid;
    int         m_idx;

    prio_encode_arb #(.WIDTH(8), .LSB_FIRST(1'b0)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .clr_all(clr_all),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .pending(pending), .any_pending(any_pending)
    );

    prio_encode_arb #(.WIDTH(8), .LSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .ena(u1_ena), .req(u1_req), .clr_all(u1_clr),
        .out_valid(u1_valid), .out_ready(u1_rdy), .out_idx(u1_idx),
        .pending(u1_pending), .any_pending(u1_any)
    );

    prio_encode_arb #(.WIDTH(32), .LSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst(rst), .ena(u2_ena), .req(u2_req), .clr_all(u2_clr),
        .out_valid(u2_valid), .out_ready(u2_rdy), .out_idx(u2_idx),
        .pending(u2_pending), .any_pending(u2_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ena, clr, rdy;
        logic [7:0] req;
        logic       ev;
        logic [2:0] ei;
        logic [7:0] ep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, e, c, rd, input logic [7:0] rq,
                                input logic ev, input logic [2:0] ei,
                                input logic [7:0] ep);
        vec_t v;
        v.rst = r; v.ena = e; v.clr = c; v.rdy = rd; v.req = rq;
        v.ev = ev; v.ei = ei; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Highest set bit, found by scanning down from the top.
    function automatic int pick_hi(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            if (v[i]) return i;
        return 0;
    endfunction

    // One clock of u0 plus the reference model, then compare u0 to the model.
    task automatic step(input logic r, input logic e, input logic c,
                        input logic rd, input logic [7:0] rq);
        logic [7:0] np;
        logic       nv;
        int         ni;
        logic       a;
        @(negedge clk);
        rst = r; ena = e; clr_all = c; out_ready = rd; req = rq;
        if (r) begin
            np = '0; nv = 1'b0; ni = 0;
        end else begin
            a  = m_valid & rd;
            np = m_pend;
            if (a) np[m_idx] = 1'b0;
            if (e) np = np | rq;
            if (c) np = '0;
            if (c) begin
                nv = 1'b0; ni = 0;
            end else if (m_valid && !a) begin
                nv = 1'b1; ni = m_idx;
            end else if (e && np != 8'h00) begin
                nv = 1'b1; ni = pick_hi(np);
            end else begin
                nv = 1'b0; ni = 0;
            end
        end
        @(posedge clk);
        #1;
        m_pend = np; m_valid = nv; m_idx = ni;
        chk("model_valid", 64'(out_valid), 64'(m_valid));
        chk("model_idx", 64'(out_idx), 64'(m_idx));
        chk("model_pending", 64'(pending), 64'(m_pend));
        chk("model_any", 64'(any_pending), 64'(m_pend != 8'h00));
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; clr_all = 1'b0; out_ready = 1'b0; req = '0;
        u1_ena = 1'b0; u1_clr = 1'b0; u1_rdy = 1'b0; u1_req = '0;
        u2_ena = 1'b0; u2_clr = 1'b0; u2_rdy = 1'b0; u2_req = '0;
        m_pend = '0; m_valid = 1'b0; m_idx = 0;

        //              rst ena clr rdy req     ev  ei  ep
        vecs.push_back(mk(1, 1, 0, 0, 8'hFF, 0, 0, 8'h00));
        vecs.push_back(mk(1, 1, 0, 0, 8'hFF, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 1, 8'h28, 1, 5, 8'h28));
        vecs.push_back(mk(0, 1, 0, 1, 8'h00, 1, 3, 8'h08));
        vecs.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 0, 8'h08, 1, 3, 8'h08));
        vecs.push_back(mk(0, 1, 0, 0, 8'h80, 1, 3, 8'h88));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 3, 8'h88));
        vecs.push_back(mk(0, 1, 0, 1, 8'h00, 1, 7, 8'h80));
        vecs.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 0, 8'h04, 1, 2, 8'h04));
        vecs.push_back(mk(0, 1, 0, 1, 8'h04, 1, 2, 8'h04));
        vecs.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 0, 8'hFF, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 0, 8'h10, 1, 4, 8'h10));
        vecs.push_back(mk(0, 0, 0, 0, 8'hFF, 1, 4, 8'h10));
        vecs.push_back(mk(0, 0, 0, 1, 8'hFF, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 0, 8'h42, 1, 6, 8'h42));
        vecs.push_back(mk(0, 1, 1, 0, 8'h01, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 0, 8'h02, 1, 1, 8'h02));
        vecs.push_back(mk(0, 1, 1, 1, 8'h00, 0, 0, 8'h00));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ena, vecs[i].clr, vecs[i].rdy, vecs[i].req);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_idx", i), 64'(out_idx), 64'(vecs[i].ei));
            chk($sformatf("vec%0d_pending", i), 64'(pending), 64'(vecs[i].ep));
            chk($sformatf("vec%0d_any", i), 64'(any_pending), 64'(vecs[i].ep != 8'h00));
        end

        // LSB_FIRST and WIDTH=32 builds, driven side by side.
        u1_ena = 1'b1; u1_rdy = 1'b1; u1_req = 8'b1001_0000;
        u2_ena = 1'b1; u2_rdy = 1'b1; u2_req = 32'h8000_0001;
        step(0, 0, 0, 0, 8'h00);
        chk("lsb_first_1st_valid", 64'(u1_valid), 64'd1);
        chk("lsb_first_1st_idx", 64'(u1_idx), 64'd4);
        chk("w32_1st_valid", 64'(u2_valid), 64'd1);
        chk("w32_1st_idx", 64'(u2_idx), 64'd31);
        u1_req = '0; u2_req = '0;
        step(0, 0, 0, 0, 8'h00);
        chk("lsb_first_2nd_idx", 64'(u1_idx), 64'd7);
        chk("lsb_first_2nd_pending", 64'(u1_pending), 64'h80);
        chk("w32_2nd_idx", 64'(u2_idx), 64'd0);
        chk("w32_2nd_pending", 64'(u2_pending), 64'h1);
        chk("w32_2nd_valid", 64'(u2_valid), 64'd1);
        step(0, 0, 0, 0, 8'h00);
        chk("lsb_first_done_valid", 64'(u1_valid), 64'd0);
        chk("lsb_first_done_any", 64'(u1_any), 64'd0);
        chk("w32_done_valid", 64'(u2_valid), 64'd0);
        chk("w32_done_any", 64'(u2_any), 64'd0);
        u2_req = 32'h0001_0000; u2_rdy = 1'b0;
        step(0, 0, 0, 0, 8'h00);
        u2_clr = 1'b1; u2_req = '0;
        step(0, 0, 0, 0, 8'h00);
        chk("w32_clr_valid", 64'(u2_valid), 64'd0);
        chk("w32_clr_pending", 64'(u2_pending), 64'h0);
        u1_ena = 1'b0; u1_rdy = 1'b0; u2_ena = 1'b0; u2_clr = 1'b0;

        // Randomized traffic on u0 against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic       r, e, c, rd;
            logic [7:0] rq;
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 7) != 0);
            c  = ($urandom_range(0, 39) == 0);
            rd = ($urandom_range(0, 2) != 0);
            rq = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom) : 8'h00;
            step(r, e, c, rd, rq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
